// File: rtl/turbosound_fm_ctrl.sv
// turbosound_fm_ctrl: CPU-side front end for CHIPS OPN (FM + PSG) chip pairs.
// Decodes chip-select, address and data writes, keeps per-chip address latch
// and prescaler, derives per-chip FM/PSG clock enables from the master CE,
// models the OPN write-busy flag and multiplexes read data for the CPU.
//
// Ports:
//   CLK, RESET       clock, asynchronous active-high reset
//   CE               master clock enable
//   A0, WE, DI       CPU port: A0 selects address/data, WE write strobe, DI data
//   DO               CPU read data (combinational)
//   OPN_DO, PSG_DO   per-chip core read data, chip i at [8i+7:8i]
//   CHIP_WE          per-chip write strobe (combinational)
//   CE_OPN, CE_PSG   per-chip registered FM / PSG clock enables
//   SEL              currently selected chip
//   BUSY             per-chip write-busy flag
module turbosound_fm_ctrl #(
   parameter int unsigned CHIPS      = 2,
   parameter int unsigned BUSY_TICKS = 32
) (
   input  logic               CLK,
   input  logic               RESET,
   input  logic               CE,
   input  logic               A0,
   input  logic               WE,
   input  logic [7:0]         DI,
   output logic [7:0]         DO,
   input  logic [8*CHIPS-1:0] OPN_DO,
   input  logic [8*CHIPS-1:0] PSG_DO,
   output logic [CHIPS-1:0]   CHIP_WE,
   output logic [CHIPS-1:0]   CE_OPN,
   output logic [CHIPS-1:0]   CE_PSG,
   output logic [1:0]         SEL,
   output logic [CHIPS-1:0]   BUSY
);

   function automatic logic [2:0] fm_limit(input logic [1:0] p);
      logic [2:0] l;
      case (p)
         2'd0:    l = 3'd1;
         2'd1:    l = 3'd1;
         2'd2:    l = 3'd5;
         default: l = 3'd2;
      endcase
      return l;
   endfunction

   function automatic logic [2:0] psg_limit(input logic [1:0] p);
      logic [2:0] l;
      case (p)
         2'd0:    l = 3'd0;
         2'd1:    l = 3'd0;
         2'd2:    l = 3'd3;
         default: l = 3'd1;
      endcase
      return l;
   endfunction

   logic             sel_code, addr_wr, data_wr;
   logic [1:0]       cand;
   logic [1:0]       sel_q, sel_d;
   logic [7:0]       ymreg_q   [CHIPS];
   logic [7:0]       ymreg_d   [CHIPS];
   logic [1:0]       pres_q    [CHIPS];
   logic [1:0]       pres_d    [CHIPS];
   logic [2:0]       fm_cnt_q  [CHIPS];
   logic [2:0]       fm_cnt_d  [CHIPS];
   logic [2:0]       psg_cnt_q [CHIPS];
   logic [2:0]       psg_cnt_d [CHIPS];
   logic [7:0]       busy_q    [CHIPS];
   logic [7:0]       busy_d    [CHIPS];
   logic [CHIPS-1:0] hit;
   logic [CHIPS-1:0] ce_opn_q, ce_opn_d, ce_psg_q, ce_psg_d;
   logic [7:0]       opn_sel, psg_sel;
   logic             busy_sel;

   // Write decode and chip select
   always_comb begin
      sel_code = (DI[7:2] == 6'h3f);
      cand     = ~DI[1:0];
      addr_wr  = WE & ~A0 & ~sel_code;
      data_wr  = WE & A0;
      sel_d    = sel_q;
      if (WE && !A0 && sel_code && (32'(cand) < CHIPS)) begin
         sel_d = cand;
      end
   end

   // Per-chip latch, prescaler, dividers and busy counter
   always_comb begin
      hit      = '0;
      CHIP_WE  = '0;
      BUSY     = '0;
      ce_opn_d = '0;
      ce_psg_d = '0;
      for (int i = 0; i < int'(CHIPS); i++) begin
         hit[i]       = (sel_q == 2'(i));
         CHIP_WE[i]   = hit[i] & (addr_wr | data_wr);
         ymreg_d[i]   = ymreg_q[i];
         pres_d[i]    = pres_q[i];
         fm_cnt_d[i]  = fm_cnt_q[i];
         psg_cnt_d[i] = psg_cnt_q[i];
         busy_d[i]    = busy_q[i];

         if (hit[i] && addr_wr) begin
            ymreg_d[i] = DI;
         end
         // Prescaler decodes the latch value held before this write
         if (hit[i] && data_wr) begin
            case (ymreg_q[i])
               8'h2d:   pres_d[i][1] = 1'b1;
               8'h2e:   pres_d[i][0] = 1'b1;
               8'h2f:   pres_d[i]    = 2'd0;
               default: ;
            endcase
         end

         ce_opn_d[i] = CE & (fm_cnt_q[i] == 3'd0);
         ce_psg_d[i] = CE & (psg_cnt_q[i] == 3'd0);
         if (CE) begin
            fm_cnt_d[i]  = (fm_cnt_q[i] >= fm_limit(pres_q[i])) ? 3'd0 : fm_cnt_q[i] + 3'd1;
            psg_cnt_d[i] = (psg_cnt_q[i] >= psg_limit(pres_q[i])) ? 3'd0 : psg_cnt_q[i] + 3'd1;
         end
         // A prescaler change restarts both dividers of that chip
         if (pres_d[i] != pres_q[i]) begin
            fm_cnt_d[i]  = 3'd0;
            psg_cnt_d[i] = 3'd0;
         end

         if (ce_opn_q[i] && (busy_q[i] != 8'd0)) begin
            busy_d[i] = busy_q[i] - 8'd1;
         end
         // Reload has priority over a coincident decrement
         if (hit[i] && data_wr && (ymreg_q[i] >= 8'h20)) begin
            busy_d[i] = 8'(BUSY_TICKS);
         end
         BUSY[i] = (busy_q[i] != 8'd0);
      end
   end

   // Read mux
   always_comb begin
      opn_sel  = '0;
      psg_sel  = '0;
      busy_sel = 1'b0;
      for (int i = 0; i < int'(CHIPS); i++) begin
         if (sel_q == 2'(i)) begin
            opn_sel  = OPN_DO[8*i +: 8];
            psg_sel  = PSG_DO[8*i +: 8];
            busy_sel = (busy_q[i] != 8'd0);
         end
      end
      DO = A0 ? psg_sel : {opn_sel[7] | busy_sel, opn_sel[6:0]};
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         sel_q    <= 2'd0;
         ce_opn_q <= '0;
         ce_psg_q <= '0;
         for (int i = 0; i < int'(CHIPS); i++) begin
            ymreg_q[i]   <= 8'd0;
            pres_q[i]    <= 2'd2;
            fm_cnt_q[i]  <= 3'd0;
            psg_cnt_q[i] <= 3'd0;
            busy_q[i]    <= 8'd0;
         end
      end else begin
         sel_q    <= sel_d;
         ce_opn_q <= ce_opn_d;
         ce_psg_q <= ce_psg_d;
         for (int i = 0; i < int'(CHIPS); i++) begin
            ymreg_q[i]   <= ymreg_d[i];
            pres_q[i]    <= pres_d[i];
            fm_cnt_q[i]  <= fm_cnt_d[i];
            psg_cnt_q[i] <= psg_cnt_d[i];
            busy_q[i]    <= busy_d[i];
         end
      end
   end

   assign SEL    = sel_q;
   assign CE_OPN = ce_opn_q;
   assign CE_PSG = ce_psg_q;

endmodule

// File: tb/tb_turbosound_fm_ctrl.sv
// Self-checking bench for turbosound_fm_ctrl (CHIPS=2, BUSY_TICKS=4).
// Expected values are queued as stimulus is applied and popped when the
// corresponding DUT output is sampled.
module tb_turbosound_fm_ctrl;

   localparam int unsigned CHIPS      = 2;
   localparam int unsigned BUSY_TICKS = 4;

   logic                 CLK = 1'b0;
   logic                 RESET, CE, A0, WE;
   logic [7:0]           DI, DO;
   logic [8*CHIPS-1:0]   OPN_DO, PSG_DO;
   logic [CHIPS-1:0]     CHIP_WE, CE_OPN, CE_PSG, BUSY;
   logic [1:0]           SEL;

   int errors = 0;
   int checks = 0;

   string       tag_q[$];
   logic [31:0] exp_q[$];

   // Pulse monitor: counts pulses, first-pulse offset and last interval
   // (in CLK cycles) since the last clear.
   logic mon_clr = 1'b0;
   int   rel;
   int   opn_n[CHIPS], opn_first[CHIPS], opn_int[CHIPS], opn_last[CHIPS];
   int   psg_n[CHIPS], psg_first[CHIPS], psg_int[CHIPS], psg_last[CHIPS];

   turbosound_fm_ctrl #(
      .CHIPS      (CHIPS),
      .BUSY_TICKS (BUSY_TICKS)
   ) dut (
      .CLK     (CLK),
      .RESET   (RESET),
      .CE      (CE),
      .A0      (A0),
      .WE      (WE),
      .DI      (DI),
      .DO      (DO),
      .OPN_DO  (OPN_DO),
      .PSG_DO  (PSG_DO),
      .CHIP_WE (CHIP_WE),
      .CE_OPN  (CE_OPN),
      .CE_PSG  (CE_PSG),
      .SEL     (SEL),
      .BUSY    (BUSY)
   );

   always #5 CLK = ~CLK;

   always @(negedge CLK) begin
      if (mon_clr) begin
         rel <= 0;
         for (int i = 0; i < int'(CHIPS); i++) begin
            opn_n[i] <= 0; opn_first[i] <= 0; opn_int[i] <= 0; opn_last[i] <= 0;
            psg_n[i] <= 0; psg_first[i] <= 0; psg_int[i] <= 0; psg_last[i] <= 0;
         end
      end else begin
         rel <= rel + 1;
         for (int i = 0; i < int'(CHIPS); i++) begin
            if (CE_OPN[i]) begin
               if (opn_n[i] == 0) opn_first[i] <= rel + 1;
               else               opn_int[i]   <= rel + 1 - opn_last[i];
               opn_last[i] <= rel + 1;
               opn_n[i]    <= opn_n[i] + 1;
            end
            if (CE_PSG[i]) begin
               if (psg_n[i] == 0) psg_first[i] <= rel + 1;
               else               psg_int[i]   <= rel + 1 - psg_last[i];
               psg_last[i] <= rel + 1;
               psg_n[i]    <= psg_n[i] + 1;
            end
         end
      end
   end

   function automatic void push(input string t, input logic [31:0] e);
      tag_q.push_back(t);
      exp_q.push_back(e);
   endfunction

   task automatic sb_check(input logic [31:0] obs);
      string       t;
      logic [31:0] e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL scoreboard_empty: observed=%0h with no expectation", obs);
      end else begin
         t = tag_q.pop_front();
         e = exp_q.pop_front();
         assert (obs === e) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", t, obs, e);
         end
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // One-cycle CPU write with check of the combinational CHIP_WE
   task automatic wr(input string t, input logic a0, input logic [7:0] d,
                     input logic [1:0] exp_we);
      WE = 1'b1; A0 = a0; DI = d; CE = 1'b0;
      #1;
      push(t, {30'b0, exp_we});
      sb_check({30'b0, CHIP_WE});
      tick();
      WE = 1'b0; A0 = 1'b0;
   endtask

   // CE every 2nd cycle for n cycles, monitor cleared in the first cycle
   task automatic window(input int n);
      for (int k = 0; k < n; k++) begin
         WE = 1'b0; CE = (k % 2 == 0); mon_clr = (k == 0);
         tick();
      end
      CE = 1'b0; mon_clr = 1'b0;
   endtask

   task automatic rates(input string t, input int ch, input int fn, input int fi,
                        input int pn, input int pi);
      push({t, "_fm_count"}, fn);
      push({t, "_fm_first"}, 1);
      push({t, "_fm_interval"}, fi);
      push({t, "_psg_count"}, pn);
      push({t, "_psg_first"}, 1);
      push({t, "_psg_interval"}, pi);
      sb_check(opn_n[ch]);
      sb_check(opn_first[ch]);
      sb_check(opn_int[ch]);
      sb_check(psg_n[ch]);
      sb_check(psg_first[ch]);
      sb_check(psg_int[ch]);
   endtask

   // Follows BUSY[0] after an FM data write; optionally rewrites data once
   // when retrig_at pulses have elapsed (counter at 1).
   task automatic busy_run(input string t, input int retrig_at);
      int   seen = 0;
      bit   done = 1'b0;
      bit   rt   = 1'b0;
      logic eb;
      for (int k = 0; k < 400 && !done; k++) begin
         eb = (seen < int'(BUSY_TICKS));
         push({t, "_busy0"}, {31'b0, eb});
         sb_check({31'b0, BUSY[0]});
         WE = 1'b0; A0 = 1'b0; CE = (k % 2 == 0);
         #1;
         push({t, "_do_busy_bit"}, {24'b0, eb, 7'b0});
         sb_check({24'b0, DO});
         if (!eb) begin
            done = 1'b1;
         end else if (!rt && retrig_at > 0 && seen == retrig_at) begin
            WE = 1'b1; A0 = 1'b1; DI = 8'h0F; rt = 1'b1; seen = 0;
         end else if (CE_OPN[0]) begin
            seen++;
         end
         tick();
      end
      WE = 1'b0; A0 = 1'b0; CE = 1'b0;
      checks++;
      assert (done) else begin
         errors++;
         $error("FAIL %s_timeout: observed=busy_still_high expected=fall_within_400", t);
      end
   endtask

   initial begin
      RESET = 1'b1; CE = 1'b0; A0 = 1'b0; WE = 1'b0; DI = 8'h00;
      OPN_DO = {8'h9C, 8'h35};
      PSG_DO = {8'h5B, 8'hA6};
      tick(); tick();
      RESET = 1'b0;
      #1;

      // Reset state and read mux for chip 0
      push("rst_sel", 0);      sb_check({30'b0, SEL});
      push("rst_busy", 0);     sb_check({30'b0, BUSY});
      push("rst_ce_opn", 0);   sb_check({30'b0, CE_OPN});
      push("rst_ce_psg", 0);   sb_check({30'b0, CE_PSG});
      push("rst_chip_we", 0);  sb_check({30'b0, CHIP_WE});
      push("rst_do_status", 32'h35); sb_check({24'b0, DO});
      A0 = 1'b1; #1;
      push("rst_do_psg", 32'hA6);    sb_check({24'b0, DO});
      A0 = 1'b0;

      // Default rates, pres=2 on both chips
      window(48);
      rates("t1c0", 0, 4, 12, 6, 8);
      rates("t1c1", 1, 4, 12, 6, 8);

      // Select chip 1, set pres=0
      wr("we_sel_fe", 1'b0, 8'hFE, 2'b00);
      push("sel_after_fe", 1); sb_check({30'b0, SEL});
      wr("we_addr_2f", 1'b0, 8'h2F, 2'b10);
      wr("we_data_c1", 1'b1, 8'h00, 2'b10);
      A0 = 1'b1; #1;
      push("do_psg_c1", 32'h5B); sb_check({24'b0, DO});
      A0 = 1'b0; #1;
      push("do_status_c1", 32'h9C); sb_check({24'b0, DO});
      window(48);
      rates("t2c1", 1, 12, 4, 24, 2);
      rates("t2c0", 0, 4, 12, 6, 8);
      push("busy_idle", 0); sb_check({30'b0, BUSY});

      // Out-of-range select code is ignored and not latched
      wr("we_addr_10", 1'b0, 8'h10, 2'b10);
      wr("we_sel_fd", 1'b0, 8'hFD, 2'b00);
      push("sel_after_fd", 1); sb_check({30'b0, SEL});
      wr("we_data_55", 1'b1, 8'h55, 2'b10);
      push("busy_no_latch_fd", 0); sb_check({30'b0, BUSY});

      // Busy flag on chip 0
      OPN_DO = {8'h9C, 8'h00};
      wr("we_sel_ff", 1'b0, 8'hFF, 2'b00);
      push("sel_after_ff", 0); sb_check({30'b0, SEL});
      wr("we_addr_28", 1'b0, 8'h28, 2'b01);
      wr("we_data_0f", 1'b1, 8'h0F, 2'b01);
      busy_run("busy", 0);

      // Retrigger at count 1
      wr("we_data_0f_b", 1'b1, 8'h0F, 2'b01);
      busy_run("retrig", 3);

      // Prescaler 2 -> 3
      wr("we_addr_2d", 1'b0, 8'h2D, 2'b01);
      wr("we_data_2d", 1'b1, 8'h00, 2'b01);
      wr("we_addr_2e", 1'b0, 8'h2E, 2'b01);
      wr("we_data_2e", 1'b1, 8'h00, 2'b01);
      window(48);
      rates("t6c0", 0, 8, 6, 12, 4);

      // Asynchronous reset mid-cycle while chip 1 is busy
      wr("we_sel_fe_b", 1'b0, 8'hFE, 2'b00);
      wr("we_addr_25", 1'b0, 8'h25, 2'b10);
      wr("we_data_25", 1'b1, 8'h00, 2'b10);
      push("busy_c1_set", 2); sb_check({30'b0, BUSY});
      push("sel_before_rst", 1); sb_check({30'b0, SEL});
      #2;
      RESET = 1'b1;
      #1;
      push("arst_sel", 0);    sb_check({30'b0, SEL});
      push("arst_busy", 0);   sb_check({30'b0, BUSY});
      push("arst_ce_opn", 0); sb_check({30'b0, CE_OPN});
      push("arst_ce_psg", 0); sb_check({30'b0, CE_PSG});
      tick();
      RESET = 1'b0;
      window(48);
      rates("t7c0", 0, 4, 12, 6, 8);
      rates("t7c1", 1, 4, 12, 6, 8);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
